// File: rtl/sram_stream_reader_if.sv
// Bus bundle for sram_stream_reader: command channel, SRAM read port,
// output stream and status. "master" is the reader's view, "slave" is the
// view of whatever surrounds it (command source, SRAM, consumer).
interface sram_stream_reader_if #(
  parameter int AW = 12,
  parameter int DW = 128,
  parameter int LW = 13
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [LW-1:0] cmd_len;

  logic          sram_enb;
  logic [AW-1:0] sram_addrb;
  logic [DW-1:0] sram_doutb;

  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  logic          busy;
  logic          done;

  modport master (
    input  cmd_valid, cmd_base, cmd_len, sram_doutb, m_ready,
    output cmd_ready, sram_enb, sram_addrb, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_len, sram_doutb, m_ready,
    input  cmd_ready, sram_enb, sram_addrb, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/sram_stream_reader.sv
// sram_stream_reader: turns a {base, length} command into SRAM reads and a
// valid/ready stream with a last marker. A 2-entry FIFO plus a credit of two
// outstanding words absorbs consumer backpressure. When the FIFO is empty the
// word returning from the SRAM is presented directly, so an unstalled stream
// runs at one beat per cycle with the first beat two cycles after accept.
// Optional: define SRAM_STREAM_READER_PERF_EN to add perf_stall_cnt/perf_beats.
module sram_stream_reader #(
  parameter int AW = 12,
  parameter int DW = 128,
  parameter int LW = 13
) (
  input  logic clk,
  input  logic rst,
  sram_stream_reader_if.master bus
`ifdef SRAM_STREAM_READER_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [LW-1:0] perf_beats
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] rd_addr_reg, rd_addr_next;
  logic [LW-1:0] issue_left_reg, issue_left_next;
  logic          inflight_reg;       // a read was issued last cycle; doutb is valid now
  logic          inflight_last_reg;  // that read is the final word of the command
  logic [DW-1:0] fifo_data [2];
  logic [1:0]    fifo_last_reg;
  logic          wr_ptr_reg, rd_ptr_reg;
  logic [1:0]    occ_reg, occ_next;
  logic          busy_reg, done_reg;

  logic          cmd_fire, issue, fifo_empty, bypass;
  logic          head_valid, head_last, beat_fire, push, pop;
  logic [DW-1:0] head_data;
  logic [2:0]    used;

  assign cmd_fire   = (state_reg == IDLE) && bus.cmd_valid;
  // Words owed to the consumer: stored in the FIFO or still coming from the SRAM.
  assign used       = {1'b0, occ_reg} + {2'b00, inflight_reg};
  assign issue      = (state_reg == READ) && (issue_left_reg != '0) && (used < 3'd2);
  assign fifo_empty = (occ_reg == 2'd0);
  assign bypass     = fifo_empty && inflight_reg;
  assign head_valid = !fifo_empty || inflight_reg;
  assign head_data  = !fifo_empty ? fifo_data[rd_ptr_reg] :
                      (inflight_reg ? bus.sram_doutb : '0);
  assign head_last  = !fifo_empty ? fifo_last_reg[rd_ptr_reg] : inflight_last_reg;
  assign beat_fire  = head_valid && bus.m_ready;
  // A returning word is stored unless it leaves straight through the bypass.
  assign push       = inflight_reg && !(bypass && bus.m_ready);
  assign pop        = !fifo_empty && bus.m_ready;
  assign occ_next   = occ_reg + {1'b0, push} - {1'b0, pop};

  assign bus.cmd_ready  = (state_reg == IDLE);
  assign bus.sram_enb   = issue;
  assign bus.sram_addrb = rd_addr_reg;
  assign bus.m_valid    = head_valid;
  assign bus.m_data     = head_data;
  assign bus.m_last     = head_valid && head_last;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;

  // State, address and remaining-issue registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      rd_addr_reg    <= '0;
      issue_left_reg <= '0;
    end else begin
      state_reg      <= state_next;
      rd_addr_reg    <= rd_addr_next;
      issue_left_reg <= issue_left_next;
    end
  end

  // Next-state logic: accept, issue reads under credit, drain to empty.
  always_comb begin
    state_next      = state_reg;
    rd_addr_next    = rd_addr_reg;
    issue_left_next = issue_left_reg;
    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid && (bus.cmd_len != '0)) begin
          rd_addr_next    = bus.cmd_base;
          issue_left_next = bus.cmd_len;
          state_next      = READ;
        end
      end
      READ: begin
        if (issue) begin
          rd_addr_next    = rd_addr_reg + AW'(1);
          issue_left_next = issue_left_reg - LW'(1);
          if (issue_left_reg == LW'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !inflight_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Track the read in flight so its data is captured the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      inflight_reg      <= issue;
      inflight_last_reg <= issue && (issue_left_reg == LW'(1));
    end
  end

  // FIFO payload; validity is carried by the occupancy count, so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_data[wr_ptr_reg] <= bus.sram_doutb;
  end

  // FIFO pointers, occupancy and per-entry last flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_last_reg <= '0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      occ_reg       <= 2'd0;
    end else begin
      if (push) begin
        fifo_last_reg[wr_ptr_reg] <= inflight_last_reg;
        wr_ptr_reg                <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      occ_reg <= occ_next;
    end
  end

  // busy spans accept to last-beat handoff; done pulses once per command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      if (cmd_fire && (bus.cmd_len != '0)) busy_reg <= 1'b1;
      else if (beat_fire && head_last)     busy_reg <= 1'b0;
      done_reg <= (cmd_fire && (bus.cmd_len == '0)) || (beat_fire && head_last);
    end
  end

`ifdef SRAM_STREAM_READER_PERF_EN
  // Stall cycles (saturating) and accepted beats, restarted per command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_beats     <= '0;
    end else if (cmd_fire) begin
      perf_stall_cnt <= '0;
      perf_beats     <= '0;
    end else begin
      if (head_valid && !bus.m_ready && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (beat_fire) perf_beats <= perf_beats + LW'(1);
    end
  end
`endif

endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- Read-side master for the team's 4096 x 128-bit dual-port SRAM. It drives the SRAM read port (enb/addrb, 1-cycle read latency on doutb) and converts a {base, length} command into a valid/ready output stream with a last-beat marker.
- It sits between the SRAM buffers and downstream compute/DMA consumers, and absorbs consumer backpressure without losing or duplicating words.

Parameters:
- AW, 12, SRAM address width; address arithmetic wraps modulo 2^AW.
- DW, 128, SRAM/stream data width.
- LW, 13, command length width; legal lengths are 0..2^AW.

Ports:
- clk  in  1  single clock; also clocks the SRAM read port.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_base  in  AW  first word address.
- cmd_len  in  LW  number of words to read.
- sram_enb  out  1  SRAM read enable.
- sram_addrb  out  AW  SRAM read address.
- sram_doutb  in  DW  SRAM read data, valid the cycle after sram_enb.
- m_valid  out  1  stream beat valid.
- m_ready  in  1  consumer accepts the beat.
- m_data  out  DW  stream data.
- m_last  out  1  marks the final beat of the command.
- busy  out  1  high from command accept until the last beat is accepted.
- done  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, cmd_ready=1, sram_enb=0, sram_addrb=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, FIFO empty, all counters 0. Reset mid-command abandons the command; no beat appears after rst deasserts.
- State IDLE: cmd_ready=1. On cmd_valid:
  - cmd_len==0: stay IDLE, pulse done next cycle, no SRAM reads.
  - otherwise: latch rd_addr=cmd_base and issue_left=cmd_len, move to READ, busy=1.
- State READ: issue a read (sram_enb=1, sram_addrb=rd_addr) in any cycle where issue_left>0 and credit>0.
  - credit = 2 - (FIFO occupancy + reads in flight).
  - Each issue decrements issue_left and increments rd_addr; 0xFFF wraps to 0x000.
  - Move to DRAIN when issue_left reaches 0.
- State DRAIN: no issues. Wait until the FIFO is empty and no read is in flight, then return to IDLE.
- Capture: the cycle after an issue, sram_doutb is written into a 2-entry output FIFO. Each entry's last flag is set when it is the word issued with issue_left==1.
- Output: the FIFO head drives m_valid/m_data/m_last; a beat transfers on m_valid&&m_ready.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - The FIFO never overflows, guaranteed by credit accounting.
- Latency: with m_ready held high, the first beat is valid 2 cycles after cmd accept (cycle 1 issues the read, cycle 2 returns data). After that there is 1 beat per cycle at full throughput.
- Completion: when the m_last beat is accepted, done=1 for exactly one cycle and busy=0 from the next cycle.
- cmd_ready stays low in READ/DRAIN; commands offered then are not accepted (cmd_valid must be held).
- A new command may be accepted in the cycle after done.
- cmd_len==4096 reads every word once, starting at cmd_base and wrapping.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.

Optional Feature:
- Macro: SRAM_STREAM_READER_PERF_EN.
- When defined:
  - Adds output port perf_stall_cnt (32 bits, reset 0). It counts cycles with m_valid=1 && m_ready=0 and saturates at 0xFFFFFFFF.
  - It clears at each command accept, in the same cycle the command is taken.
  - Adds output port perf_beats (LW bits, reset 0), counting accepted beats of the current command.
- When undefined: neither port nor their logic exists; all other behaviour is identical.

Test Plan:
- base=0x010, len=4, m_ready=1 -> reads at 0x010..0x013 on consecutive cycles; 4 beats with data equal to preloaded words; m_last on beat 4; done 1 cycle after that; first beat 2 cycles after accept.
- base=0xFFE, len=4 -> sram_addrb sequence 0xFFE, 0xFFF, 0x000, 0x001; data order matches.
- len=8, m_ready toggling 1,0,0,1,... -> exactly 8 beats, no duplicates or drops; m_data/m_last stable during stalls; sram_enb never issued with credit=0.
- len=0 -> no sram_enb, no m_valid, done pulse 1 cycle after accept, busy stays 0.
- len=4096, base=0x123 -> 4096 beats covering every address once; last beat carries address 0x122's data.
- rst asserted after 3 of 6 beats -> all outputs at reset values immediately; m_valid stays 0 after release until a new command. With PERF_EN: 5 forced stall cycles -> perf_stall_cnt=5.
